obi_axi_bridge: RTL and testbench

OBI_AXI_BRIDGE -- requirements
Module: obi_axi_bridge

---
 rtl/obi_axi_bridge_if.sv | 88 ++++++++
 rtl/obi_axi_bridge.sv | 189 ++++++++++++++++++
 tb/tb_obi_axi_bridge.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_axi_bridge_if.sv
// AXI_BUS: single-clock AXI4 bundle with Master/Slave modports, shared by the
// OBI-to-AXI bridge and whatever AXI slave sits behind it.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 16,
  parameter int AXI_USER_WIDTH = 10
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/obi_axi_bridge.sv
// OBI data port to single-beat AXI4 master, one transaction outstanding.
// Define OBI_AXI_ERR_EN to report non-OKAY B/R responses on data_err_o.
module obi_axi_bridge #(
  parameter int                      AXI_ADDR_WIDTH = 32,
  parameter int                      AXI_DATA_WIDTH = 32,
  parameter int                      AXI_ID_WIDTH   = 16,
  parameter int                      AXI_USER_WIDTH = 10,
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] data_be_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_wdata_i,
  output logic                        data_rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_rdata_o,
  output logic                        data_err_o,
  AXI_BUS.Master                      AXI_Master
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_e;

  state_e                      state_q, state_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic [AXI_ADDR_WIDTH-1:2]   addr_q;
  logic [AXI_DATA_WIDTH/8-1:0] be_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;
  logic                        rvalid_q;

  logic gnt, aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic aw_fire, w_fire, b_fire, r_fire;

  always_comb begin
    // NOTE: everything driven here gets a default first, so no branch can infer a latch.
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    gnt       = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    ar_valid  = 1'b0;
    b_ready   = 1'b0;
    r_ready   = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    b_fire    = 1'b0;
    r_fire    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt = data_req_i;
        if (data_req_i) state_d = data_we_i ? WR : RD_ADDR;
      end
      WR: begin
        // Each valid drops after its own handshake; leave once both have landed.
        aw_valid = !aw_done_q;
        w_valid  = !w_done_q;
        aw_fire  = !aw_done_q && AXI_Master.aw_ready;
        w_fire   = !w_done_q && AXI_Master.w_ready;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q || aw_fire;
          w_done_d  = w_done_q || w_fire;
        end
      end
      WR_RESP: begin
        b_ready = 1'b1;
        b_fire  = AXI_Master.b_valid;
        if (AXI_Master.b_valid) state_d = IDLE;
      end
      RD_ADDR: begin
        ar_valid = 1'b1;
        if (AXI_Master.ar_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        r_ready = 1'b1;
        r_fire  = AXI_Master.r_valid;
        if (AXI_Master.r_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // NOTE: payload registers are reset as well so the AXI payload never carries X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (gnt) begin
      addr_q  <= data_addr_i[AXI_ADDR_WIDTH-1:2];
      be_q    <= data_be_i;
      wdata_q <= data_wdata_i;
    end
  end

  // Response leaves one cycle after the B/R handshake; write responses carry 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= b_fire || r_fire;
      if (b_fire)      rdata_q <= '0;
      else if (r_fire) rdata_q <= AXI_Master.r_data;
    end
  end

  logic unused_rsp;

`ifdef OBI_AXI_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= (b_fire && (AXI_Master.b_resp != 2'b00)) ||
                          (r_fire && (AXI_Master.r_resp != 2'b00));
  end
  assign data_err_o = err_q;
  assign unused_rsp = ^{data_addr_i[1:0], AXI_Master.b_id, AXI_Master.b_user,
                        AXI_Master.r_id, AXI_Master.r_last, AXI_Master.r_user};
`else
  assign data_err_o = 1'b0;
  assign unused_rsp = ^{data_addr_i[1:0], AXI_Master.b_id, AXI_Master.b_user,
                        AXI_Master.b_resp, AXI_Master.r_id, AXI_Master.r_last,
                        AXI_Master.r_user, AXI_Master.r_resp};
`endif

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;

  assign AXI_Master.aw_id     = AXI_ID;
  assign AXI_Master.aw_addr   = {addr_q, 2'b00};
  assign AXI_Master.aw_len    = 8'd0;
  assign AXI_Master.aw_size   = 3'b010;
  assign AXI_Master.aw_burst  = 2'b01;
  assign AXI_Master.aw_lock   = 1'b0;
  assign AXI_Master.aw_cache  = 4'd0;
  assign AXI_Master.aw_prot   = 3'd0;
  assign AXI_Master.aw_qos    = 4'd0;
  assign AXI_Master.aw_region = 4'd0;
  assign AXI_Master.aw_atop   = 6'd0;
  assign AXI_Master.aw_user   = {AXI_USER_WIDTH{1'b0}};
  assign AXI_Master.aw_valid  = aw_valid;

  assign AXI_Master.w_data    = wdata_q;
  assign AXI_Master.w_strb    = be_q;
  assign AXI_Master.w_last    = 1'b1;
  assign AXI_Master.w_user    = {AXI_USER_WIDTH{1'b0}};
  assign AXI_Master.w_valid   = w_valid;

  assign AXI_Master.b_ready   = b_ready;

  assign AXI_Master.ar_id     = AXI_ID;
  assign AXI_Master.ar_addr   = {addr_q, 2'b00};
  assign AXI_Master.ar_len    = 8'd0;
  assign AXI_Master.ar_size   = 3'b010;
  assign AXI_Master.ar_burst  = 2'b01;
  assign AXI_Master.ar_lock   = 1'b0;
  assign AXI_Master.ar_cache  = 4'd0;
  assign AXI_Master.ar_prot   = 3'd0;
  assign AXI_Master.ar_qos    = 4'd0;
  assign AXI_Master.ar_region = 4'd0;
  assign AXI_Master.ar_user   = {AXI_USER_WIDTH{1'b0}};
  assign AXI_Master.ar_valid  = ar_valid;

  assign AXI_Master.r_ready   = r_ready;

endmodule

// File: tb/tb_obi_axi_bridge.sv
// Bench for obi_axi_bridge: directed vector table, back-to-back, reset and
// randomized traffic against a word-memory model; honours OBI_AXI_ERR_EN.
module tb_obi_axi_bridge;

  localparam logic [15:0] TB_ID = 16'h005A;
`ifdef OBI_AXI_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16),
            .AXI_USER_WIDTH(10)) axi ();

  obi_axi_bridge #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16),
    .AXI_USER_WIDTH(10), .AXI_ID(TB_ID)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o),
    .AXI_Master(axi)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  int rv_count = 0;
  initial forever begin
    @(negedge clk_i);
    #1;
    if (data_rvalid_o) rv_count++;
  end

  // ---------------- AXI slave with ready/latency knobs and protocol monitor
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_lat = 0, r_lat = 0;
  logic [1:0] resp_code = 2'b00;

  int aw_cnt, w_cnt, ar_cnt;
  int b_cnt = -1, r_cnt = -1;
  logic [1:0] b_resp_p, r_resp_p;
  logic [31:0] r_data_p;
  bit aw_have, w_have;
  logic [31:0] pend_addr, pend_data;
  logic [3:0] pend_strb;
  logic [31:0] smem [int];

  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, first_bready_cyc = -1;
  logic [31:0] last_aw_addr = '0, last_ar_addr = '0, last_w_data = '0;
  logic [3:0] last_w_strb = '0;
  int proto_err = 0;

  bit aw_stall, w_stall, ar_stall;
  logic [31:0] aw_addr_prev, ar_addr_prev, w_data_prev;
  logic [3:0] w_strb_prev;

  task automatic slave_clear();
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = -1; r_cnt = -1;
    aw_have = 0; w_have = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
    axi.b_valid = 0; axi.b_id = '0; axi.b_resp = 2'b00; axi.b_user = '0;
    axi.r_valid = 0; axi.r_id = '0; axi.r_data = '0; axi.r_resp = 2'b00;
    axi.r_last = 0; axi.r_user = '0;
  endtask

  initial begin
    bit aw_f, w_f, ar_f, b_f, r_f;
    logic [31:0] word;
    int widx;
    slave_clear();
    forever begin
      @(negedge clk_i);
      if (!rst_ni) slave_clear();
      else begin
        axi.b_valid = (b_cnt == 0);
        axi.b_resp  = axi.b_valid ? b_resp_p : 2'b00;
        axi.r_valid = (r_cnt == 0);
        axi.r_data  = axi.r_valid ? r_data_p : '0;
        axi.r_resp  = axi.r_valid ? r_resp_p : 2'b00;
        axi.r_last  = axi.r_valid;
        axi.aw_ready = axi.aw_valid && (aw_cnt >= aw_dly);
        axi.w_ready  = axi.w_valid && (w_cnt >= w_dly);
        axi.ar_ready = axi.ar_valid && (ar_cnt >= ar_dly);

        if (axi.ar_valid && (axi.aw_valid || axi.w_valid)) proto_err++;
        if (axi.b_ready && (axi.r_ready || axi.aw_valid || axi.w_valid)) proto_err++;
        if (aw_stall && (!axi.aw_valid || axi.aw_addr !== aw_addr_prev)) proto_err++;
        if (ar_stall && (!axi.ar_valid || axi.ar_addr !== ar_addr_prev)) proto_err++;
        if (w_stall && (!axi.w_valid || axi.w_data !== w_data_prev ||
                        axi.w_strb !== w_strb_prev)) proto_err++;
        if (axi.aw_valid && (axi.aw_addr[1:0] != 2'b00 || axi.aw_len != 0 ||
            axi.aw_size != 3'b010 || axi.aw_burst != 2'b01 || axi.aw_id != TB_ID ||
            axi.aw_lock || axi.aw_cache != 0 || axi.aw_prot != 0 || axi.aw_qos != 0 ||
            axi.aw_region != 0 || axi.aw_atop != 0 || axi.aw_user != 0)) proto_err++;
        if (axi.ar_valid && (axi.ar_addr[1:0] != 2'b00 || axi.ar_len != 0 ||
            axi.ar_size != 3'b010 || axi.ar_burst != 2'b01 || axi.ar_id != TB_ID ||
            axi.ar_lock || axi.ar_cache != 0 || axi.ar_prot != 0 || axi.ar_qos != 0 ||
            axi.ar_region != 0 || axi.ar_user != 0)) proto_err++;
        if (axi.w_valid && (axi.w_last !== 1'b1 || axi.w_user != 0)) proto_err++;
        if (axi.b_ready && first_bready_cyc < 0) first_bready_cyc = cyc;

        aw_f = axi.aw_valid && axi.aw_ready;
        w_f  = axi.w_valid && axi.w_ready;
        ar_f = axi.ar_valid && axi.ar_ready;
        b_f  = axi.b_valid && axi.b_ready;
        r_f  = axi.r_valid && axi.r_ready;

        aw_stall = axi.aw_valid && !aw_f; aw_addr_prev = axi.aw_addr;
        ar_stall = axi.ar_valid && !ar_f; ar_addr_prev = axi.ar_addr;
        w_stall  = axi.w_valid && !w_f;
        w_data_prev = axi.w_data; w_strb_prev = axi.w_strb;

        if (aw_f) begin
          aw_hs++; aw_hs_cyc = cyc; last_aw_addr = axi.aw_addr;
          aw_have = 1; pend_addr = axi.aw_addr; aw_cnt = 0;
        end else if (axi.aw_valid) aw_cnt++;
        if (w_f) begin
          w_hs++; w_hs_cyc = cyc; last_w_data = axi.w_data; last_w_strb = axi.w_strb;
          w_have = 1; pend_data = axi.w_data; pend_strb = axi.w_strb; w_cnt = 0;
        end else if (axi.w_valid) w_cnt++;

        if (b_f) begin b_hs++; b_cnt = -1; end
        else if (b_cnt > 0) b_cnt--;
        if (aw_have && w_have) begin
          widx = int'(pend_addr >> 2);
          word = smem.exists(widx) ? smem[widx] : 32'h0;
          for (int i = 0; i < 4; i++)
            if (pend_strb[i]) word[8*i +: 8] = pend_data[8*i +: 8];
          smem[widx] = word;
          aw_have = 0; w_have = 0;
          b_cnt = b_lat; b_resp_p = resp_code;
        end

        if (r_f) begin r_hs++; r_cnt = -1; end
        else if (r_cnt > 0) r_cnt--;
        if (ar_f) begin
          ar_hs++; last_ar_addr = axi.ar_addr; ar_cnt = 0;
          widx = int'(axi.ar_addr >> 2);
          r_data_p = smem.exists(widx) ? smem[widx] : 32'h0;
          r_resp_p = resp_code; r_cnt = r_lat;
        end else if (axi.ar_valid) ar_cnt++;
      end
    end
  end

  // ---------------- OBI master
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] rd, output bit er,
                         output int lat, output bit seen, output bit pulse_ok);
    int n, gcyc;
    @(negedge clk_i);
    data_req_i = 1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wd;
    #1;
    n = 0;
    while (!data_gnt_o && n < 50) begin @(negedge clk_i); #1; n++; end
    seen = data_gnt_o;
    gcyc = cyc;
    @(negedge clk_i);
    data_req_i = 0;
    #1;
    n = 0;
    while (!data_rvalid_o && n < 100) begin @(negedge clk_i); #1; n++; end
    seen = seen && data_rvalid_o;
    lat = cyc - gcyc; rd = data_rdata_o; er = data_err_o;
    @(negedge clk_i);
    #1;
    pulse_ok = !data_rvalid_o;
  endtask

  task automatic exec(input string tag, input bit we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_er, input int exp_lat);
    logic [31:0] rd, hs;
    bit er, seen, pulse_ok;
    int lat, aw0, w0, ar0, b0, r0;
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs; b0 = b_hs; r0 = r_hs;
    first_bready_cyc = -1;
    run_txn(we, addr, be, wd, rd, er, lat, seen, pulse_ok);
    check({tag, ".completed"}, 32'(seen), 32'd1);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, 32'(er), 32'(exp_er));
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rvalid_1cyc"}, 32'(pulse_ok), 32'd1);
    hs = 32'(((aw_hs - aw0) << 16) | ((w_hs - w0) << 12) | ((ar_hs - ar0) << 8) |
             ((b_hs - b0) << 4) | (r_hs - r0));
    check({tag, ".handshakes"}, hs, we ? 32'h0001_1010 : 32'h0000_0101);
    if (we) begin
      check({tag, ".aw_addr"}, last_aw_addr, addr & 32'hFFFF_FFFC);
      check({tag, ".w_strb"}, 32'(last_w_strb), 32'(be));
      check({tag, ".w_data"}, last_w_data, wd);
    end else begin
      check({tag, ".ar_addr"}, last_ar_addr, addr & 32'hFFFF_FFFC);
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  logic [31:0] model [int];

  initial begin
    vec_t vecs[9];
    logic [31:0] rd_pre;
    int rv0, n;

    vecs[0] = '{1, 32'h100, 4'hF, 32'hDEADBEEF, 0, 0, 2'b00, 32'h0, 0, 3};
    vecs[1] = '{0, 32'h100, 4'hF, 32'h0, 0, 0, 2'b00, 32'hDEADBEEF, 0, 3};
    vecs[2] = '{1, 32'h103, 4'b0100, 32'h11223344, 3, 0, 2'b00, 32'h0, 0, 6};
    vecs[3] = '{0, 32'h100, 4'hF, 32'h0, 0, 0, 2'b00, 32'hDE22BEEF, 0, 3};
    vecs[4] = '{1, 32'h104, 4'b0011, 32'hCAFEF00D, 0, 2, 2'b00, 32'h0, 0, 5};
    vecs[5] = '{0, 32'h106, 4'hF, 32'h0, 0, 0, 2'b00, 32'h0000F00D, 0, 3};
    vecs[6] = '{0, 32'h100, 4'hF, 32'h0, 0, 0, 2'b10, 32'hDE22BEEF, ERR_EN, 3};
    vecs[7] = '{1, 32'h108, 4'hF, 32'h0BADC0DE, 1, 1, 2'b10, 32'h0, ERR_EN, 4};
    vecs[8] = '{0, 32'h108, 4'hF, 32'h0, 0, 0, 2'b00, 32'h0BADC0DE, 0, 3};

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    check("reset.rvalid", 32'(data_rvalid_o), 32'd0);
    check("reset.rdata", data_rdata_o, 32'd0);
    check("reset.err", 32'(data_err_o), 32'd0);
    check("reset.axi_hs", 32'({axi.aw_valid, axi.w_valid, axi.ar_valid,
                               axi.b_ready, axi.r_ready}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1;
    repeat (2) @(negedge clk_i);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      aw_dly = vecs[i].aw_dly; w_dly = vecs[i].w_dly; ar_dly = 0;
      b_lat = 0; r_lat = 0; resp_code = vecs[i].resp;
      exec($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
           vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
      if (i == 0) check("vec0.aw_w_same_cycle", 32'(aw_hs_cyc - w_hs_cyc), 32'd0);
      if (i == 2) begin
        check("vec2.aw_after_w", 32'(aw_hs_cyc - w_hs_cyc), 32'd3);
        check("vec2.wr_resp_after_both", 32'(first_bready_cyc - aw_hs_cyc), 32'd1);
      end
    end
    resp_code = 2'b00; aw_dly = 0; w_dly = 0;

    // Back-to-back with request held: second grant on the first rvalid cycle
    begin
      int g_b, r_a;
      @(negedge clk_i);
      data_req_i = 1; data_we_i = 1; data_addr_i = 32'h120; data_be_i = 4'hF;
      data_wdata_i = 32'h55AA55AA;
      #1;
      n = 0;
      while (!data_gnt_o && n < 50) begin @(negedge clk_i); #1; n++; end
      check("b2b.gnt_a", 32'(data_gnt_o), 32'd1);
      @(negedge clk_i);
      data_we_i = 0; data_wdata_i = 32'h0;
      #1;
      r_a = -1; n = 0;
      while (!data_gnt_o && n < 50) begin
        if (data_rvalid_o && r_a < 0) r_a = cyc;
        @(negedge clk_i); #1; n++;
      end
      if (data_rvalid_o && r_a < 0) r_a = cyc;
      g_b = cyc;
      check("b2b.gnt_b_on_rvalid_a", 32'(g_b - r_a), 32'd0);
      check("b2b.rdata_a", data_rdata_o, 32'h0);
      @(negedge clk_i);
      data_req_i = 0;
      #1;
      n = 0;
      while (!data_rvalid_o && n < 50) begin @(negedge clk_i); #1; n++; end
      check("b2b.rdata_b", data_rdata_o, 32'h55AA55AA);
    end

    // Reset while in RD_DATA
    r_lat = 4;
    @(negedge clk_i);
    #1;
    rd_pre = data_rdata_o;
    check("rst.pre_rdata", rd_pre, 32'h55AA55AA);
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h100;
    n = 0;
    while (!data_gnt_o && n < 50) begin @(negedge clk_i); #1; n++; end
    @(negedge clk_i);
    data_req_i = 0;
    #1;
    n = 0;
    while (!axi.r_ready && n < 50) begin @(negedge clk_i); #1; n++; end
    check("rst.reached_rd_data", 32'(axi.r_ready), 32'd1);
    rv0 = rv_count;
    #2;
    rst_ni = 0;
    #1;
    check("rst.outputs", {data_rdata_o[30:0], data_rvalid_o}, 32'd0);
    check("rst.err_gnt", 32'({data_err_o, data_gnt_o}), 32'd0);
    check("rst.axi_hs", 32'({axi.aw_valid, axi.w_valid, axi.ar_valid,
                             axi.b_ready, axi.r_ready}), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    r_lat = 0;
    repeat (8) @(negedge clk_i);
    #1;
    check("rst.no_response", 32'(rv_count - rv0), 32'd0);
    exec("post_rst", 0, 32'h120, 4'hF, 32'h0, 32'h55AA55AA, 0, 3);

    // Randomized traffic against the memory model
    for (int t = 0; t < 60; t++) begin
      bit we;
      logic [31:0] addr, wd, exp_rd;
      logic [3:0] be;
      int widx, lat;
      we = 1'($urandom_range(0, 1));
      addr = 32'h200 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      b_lat = $urandom_range(0, 2); r_lat = $urandom_range(0, 2);
      resp_code = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      widx = int'(addr >> 2);
      if (we) begin
        exp_rd = model.exists(widx) ? model[widx] : 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) exp_rd[8*i +: 8] = wd[8*i +: 8];
        model[widx] = exp_rd;
        exp_rd = 32'h0;
        lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_lat;
      end else begin
        exp_rd = model.exists(widx) ? model[widx] : 32'h0;
        lat = 3 + ar_dly + r_lat;
      end
      exec($sformatf("rnd%0d", t), we, addr, be, wd, exp_rd,
           ERR_EN && (resp_code != 2'b00), lat);
    end

    check("axi_protocol_violations", 32'(proto_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
